// File: rtl/tg_mux_sel_ctrl.sv
// Select-line controller for the transmission-gate 2:1 mux cell.
// Enforces break-before-make with a programmable dead time and settle time.
module tg_mux_sel_ctrl #(
  parameter int DEAD_CYC   = 2,
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  output logic       ckn1,
  output logic       ckp1,
  output logic       ckn2,
  output logic       ckp2,
  output logic [1:0] cur_sel,
  output logic       settled,
  output logic       err_sticky,
  input  logic       err_clr
);

  typedef enum logic [2:0] {
    OFF_ST = 3'd0,
    ON1_ST = 3'd1,
    ON2_ST = 3'd2,
    BREAK  = 3'd3,
    MAKE   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_OFF = 2'b00;
  localparam logic [1:0] SEL_D1  = 2'b01;
  localparam logic [1:0] SEL_D2  = 2'b10;
  localparam logic [1:0] SEL_BAD = 2'b11;

  localparam logic [CNT_W-1:0] DEAD_LD   = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  state_t           state, state_nx;
  logic [1:0]       tgt, tgt_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic       accept;
  logic [1:0] sel_eff;
  logic [1:0] stable_sel;
  logic       ckn1_nx, ckn2_nx, settled_nx, err_nx;
  logic [1:0] cur_sel_nx;

  assign accept  = req_valid && req_ready;
  // An illegal target is treated as "both off".
  assign sel_eff = (req_sel == SEL_BAD) ? SEL_OFF : req_sel;

  always_comb begin
    case (state)
      ON1_ST:  stable_sel = SEL_D1;
      ON2_ST:  stable_sel = SEL_D2;
      default: stable_sel = SEL_OFF;
    endcase
  end

  // State register; every output is registered from its *_nx value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= OFF_ST;
      tgt        <= SEL_OFF;
      cnt        <= '0;
      ckn1       <= 1'b0;
      ckp1       <= 1'b1;
      ckn2       <= 1'b0;
      ckp2       <= 1'b1;
      cur_sel    <= SEL_OFF;
      settled    <= 1'b1;
      req_ready  <= 1'b1;
      err_sticky <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nx;
      tgt        <= tgt_nx;
      cnt        <= cnt_nx;
      ckn1       <= ckn1_nx;
      ckp1       <= ~ckn1_nx;
      ckn2       <= ckn2_nx;
      ckp2       <= ~ckn2_nx;
      cur_sel    <= cur_sel_nx;
      settled    <= settled_nx;
      req_ready  <= settled_nx;
      err_sticky <= err_nx;
    end
  end

  // Next-state and timing counter.
  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    state_nx = state;
    tgt_nx   = tgt;
    cnt_nx   = cnt;
    case (state)
      OFF_ST, ON1_ST, ON2_ST: begin
        if (accept && (sel_eff != stable_sel)) begin
          tgt_nx = sel_eff;
          if (state == OFF_ST) begin
            state_nx = MAKE;
            cnt_nx   = SETTLE_LD;
          end else begin
            state_nx = BREAK;
            cnt_nx   = DEAD_LD;
          end
        end
      end
      BREAK: begin
        if (cnt == '0) begin
          if (tgt == SEL_OFF) begin
            state_nx = OFF_ST;
            cnt_nx   = '0;
          end else begin
            state_nx = MAKE;
            cnt_nx   = SETTLE_LD;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      MAKE: begin
        if (cnt == '0) state_nx = (tgt == SEL_D1) ? ON1_ST : ON2_ST;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: begin
        state_nx = OFF_ST;
        tgt_nx   = SEL_OFF;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state, so outputs change on the same edge.
  always_comb begin
    ckn1_nx    = 1'b0;
    ckn2_nx    = 1'b0;
    cur_sel_nx = SEL_OFF;
    settled_nx = 1'b0;
    case (state_nx)
      OFF_ST: settled_nx = 1'b1;
      ON1_ST: begin
        ckn1_nx    = 1'b1;
        cur_sel_nx = SEL_D1;
        settled_nx = 1'b1;
      end
      ON2_ST: begin
        ckn2_nx    = 1'b1;
        cur_sel_nx = SEL_D2;
        settled_nx = 1'b1;
      end
      MAKE: begin
        ckn1_nx    = (tgt_nx == SEL_D1);
        ckn2_nx    = (tgt_nx == SEL_D2);
        cur_sel_nx = tgt_nx;
      end
      default: ;
    endcase
  end

  // An illegal accept outranks a simultaneous clear.
  always_comb begin
    err_nx = err_sticky;
    if (err_clr) err_nx = 1'b0;
    if (accept && (req_sel == SEL_BAD)) err_nx = 1'b1;
  end

endmodule

// File: tb/tb_tg_mux_sel_ctrl.sv
// Directed bench for tg_mux_sel_ctrl: default timing instance plus a
// DEAD_CYC=1/SETTLE_CYC=1 instance for back-to-back switching.
module tb_tg_mux_sel_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rv_a, rr_a, ckn1_a, ckp1_a, ckn2_a, ckp2_a, st_a, err_a, ec_a;
  logic [1:0] sel_a, cs_a;
  logic       rv_b, rr_b, ckn1_b, ckp1_b, ckn2_b, ckp2_b, st_b, err_b, ec_b;
  logic [1:0] sel_b, cs_b;

  tg_mux_sel_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_ready(rr_a), .req_sel(sel_a),
    .ckn1(ckn1_a), .ckp1(ckp1_a), .ckn2(ckn2_a), .ckp2(ckp2_a), .cur_sel(cs_a),
    .settled(st_a), .err_sticky(err_a), .err_clr(ec_a)
  );

  tg_mux_sel_ctrl #(.DEAD_CYC(1), .SETTLE_CYC(1), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_ready(rr_b), .req_sel(sel_b),
    .ckn1(ckn1_b), .ckp1(ckp1_b), .ckn2(ckn2_b), .ckp2(ckp2_b), .cur_sel(cs_b),
    .settled(st_b), .err_sticky(err_b), .err_clr(ec_b)
  );

  // {req_ready, settled, cur_sel, ckn1, ckp1, ckn2, ckp2}
  localparam logic [7:0] X_OFF   = 8'b11_00_0101;
  localparam logic [7:0] X_ON1   = 8'b11_01_1001;
  localparam logic [7:0] X_ON2   = 8'b11_10_0110;
  localparam logic [7:0] X_BRK   = 8'b00_00_0101;
  localparam logic [7:0] X_MAKE1 = 8'b00_01_1001;
  localparam logic [7:0] X_MAKE2 = 8'b00_10_0110;

  wire [7:0] oa = {rr_a, st_a, cs_a, ckn1_a, ckp1_a, ckn2_a, ckp2_a};
  wire [7:0] ob = {rr_b, st_b, cs_b, ckn1_b, ckp1_b, ckn2_b, ckp2_b};

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gate invariants on every cycle after reset has been applied.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("a_gates", {ckn1_a & ckn2_a, ckp1_a ^ ckn1_a, ckp2_a ^ ckn2_a}, 3'b011);
      chk("b_gates", {ckn1_b & ckn2_b, ckp1_b ^ ckn1_b, ckp2_b ^ ckn2_b}, 3'b011);
    end
  end

  initial begin
    rst_n = 1'b0;
    rv_a = 0; sel_a = 2'b00; ec_a = 0;
    rv_b = 0; sel_b = 2'b00; ec_b = 0;
    step();
    chk("rst_a", oa, X_OFF);
    chk("rst_err_a", {7'd0, err_a}, 8'd0);
    chk("rst_b", ob, X_OFF);
    rst_n = 1'b1;

    // 1: off -> D1, settle 3
    rv_a = 1; sel_a = 2'b01; step(); rv_a = 0;
    chk("t1_e0", oa, X_MAKE1);
    step(); chk("t1_e1", oa, X_MAKE1);
    step(); chk("t1_e2", oa, X_MAKE1);
    step(); chk("t1_e3", oa, X_ON1);

    // 2: D1 -> D2, dead 2 then settle 3
    rv_a = 1; sel_a = 2'b10; step(); rv_a = 0;
    chk("t2_e0", oa, X_BRK);
    step(); chk("t2_e1", oa, X_BRK);
    step(); chk("t2_e2", oa, X_MAKE2);
    step(); chk("t2_e3", oa, X_MAKE2);
    step(); chk("t2_e4", oa, X_MAKE2);
    step(); chk("t2_e5", oa, X_ON2);

    // 3: D2 -> off, then redundant off request
    rv_a = 1; sel_a = 2'b00; step(); rv_a = 0;
    chk("t3_e0", oa, X_BRK);
    step(); chk("t3_e1", oa, X_BRK);
    step(); chk("t3_e2", oa, X_OFF);
    rv_a = 1; step(); rv_a = 0;
    chk("t3_same", oa, X_OFF);
    step(); chk("t3_same2", oa, X_OFF);

    // 4: illegal request, err_sticky set/clear/priority
    rv_a = 1; sel_a = 2'b01; step(); rv_a = 0;
    step(); step(); step(); chk("t4_on1", oa, X_ON1);
    rv_a = 1; sel_a = 2'b11; step(); rv_a = 0;
    chk("t4_e0", oa, X_BRK);
    chk("t4_err_set", {7'd0, err_a}, 8'd1);
    step(); chk("t4_e1", oa, X_BRK);
    step(); chk("t4_e2", oa, X_OFF);
    chk("t4_err_hold", {7'd0, err_a}, 8'd1);
    ec_a = 1; step(); ec_a = 0;
    chk("t4_err_clr", {7'd0, err_a}, 8'd0);
    ec_a = 1; rv_a = 1; sel_a = 2'b11; step(); ec_a = 0; rv_a = 0;
    chk("t4_err_win", {7'd0, err_a}, 8'd1);
    chk("t4_off_stay", oa, X_OFF);
    ec_a = 1; step(); ec_a = 0;
    chk("t4_err_clr2", {7'd0, err_a}, 8'd0);

    // 5: reset in BREAK (with err set), reset in MAKE, ignored valid while busy
    rv_a = 1; sel_a = 2'b01; step(); rv_a = 0;
    step(); step(); step(); chk("t5_on1", oa, X_ON1);
    rv_a = 1; sel_a = 2'b11; step(); rv_a = 0;
    chk("t5_brk", oa, X_BRK);
    rst_n = 0; step(); rst_n = 1;
    chk("t5_rst_brk", oa, X_OFF);
    chk("t5_rst_err", {7'd0, err_a}, 8'd0);
    rv_a = 1; sel_a = 2'b01; step(); rv_a = 0;
    chk("t5_make", oa, X_MAKE1);
    rst_n = 0; step(); rst_n = 1;
    chk("t5_rst_make", oa, X_OFF);
    rv_a = 1; sel_a = 2'b01; step();
    chk("t5b_e0", oa, X_MAKE1);
    sel_a = 2'b10; step(); chk("t5b_e1", oa, X_MAKE1);
    rv_a = 0; step(); chk("t5b_e2", oa, X_MAKE1);
    rv_a = 1; step(); rv_a = 0;
    chk("t5b_e3", oa, X_ON1);
    step(); chk("t5b_e4", oa, X_ON1);
    rv_a = 1; sel_a = 2'b10; step();
    chk("t5c_e0", oa, X_BRK);
    sel_a = 2'b00; step(); rv_a = 0;
    chk("t5c_e1", oa, X_BRK);
    step(); chk("t5c_e2", oa, X_MAKE2);

    // 6: DEAD_CYC=1, SETTLE_CYC=1, requests held valid back to back
    rv_b = 1; sel_b = 2'b01; step();
    chk("t6_e0", ob, X_MAKE1);
    sel_b = 2'b10; step(); chk("t6_e1", ob, X_ON1);
    step(); chk("t6_e2", ob, X_BRK);
    sel_b = 2'b01; step(); chk("t6_e3", ob, X_MAKE2);
    step(); chk("t6_e4", ob, X_ON2);
    step(); chk("t6_e5", ob, X_BRK);
    rv_b = 0; step(); chk("t6_e6", ob, X_MAKE1);
    step(); chk("t6_e7", ob, X_ON1);
    step(); chk("t6_e8", ob, X_ON1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/tg_mux_sel_ctrl.md
Name: tg_mux_sel_ctrl

Overview:
- Digital controller that drives the four select lines (ckn1/ckp1, ckn2/ckp2) of the transmission-gate 2:1 mux cell.
- Accepts path-change requests over a valid/ready handshake.
- Guarantees break-before-make: both paths off for a programmable dead time, then the new path on for a settle time before reporting settled.
- Sits between neuron-array sequencing logic and the analog TG mux models.

Parameters:
- DEAD_CYC, 2: cycles with both paths off during a path-to-path switch; legal range 1..2^CNT_W-1.
- SETTLE_CYC, 3: cycles after the new path turns on before settled/req_ready reassert; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the internal timing counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_sel  in  2  target: 00 = both off, 01 = D1 path, 10 = D2 path, 11 = illegal.
- ckn1  out  1  NMOS gate, path 1 (1 = on).
- ckp1  out  1  PMOS gate, path 1 (0 = on).
- ckn2  out  1  NMOS gate, path 2 (1 = on).
- ckp2  out  1  PMOS gate, path 2 (0 = on).
- cur_sel  out  2  path currently driving S; 00 while both are off.
- settled  out  1  output path stable and timing complete.
- err_sticky  out  1  an illegal req_sel was accepted.
- err_clr  in  1  clears err_sticky.

Behaviour:
- All outputs are registered.
- ckp_k is always the complement of ckn_k, so a path is never half-on.
- Paths 1 and 2 are never both on in any cycle.
- Reset (rst_n=0 at an edge): state OFF_ST, ckn1=ckn2=0, ckp1=ckp2=1, cur_sel=00, settled=1, req_ready=1, err_sticky=0, counter=0.
  - Reset mid-transition aborts immediately to this state.
- States:
  - OFF_ST, ON1_ST, ON2_ST: stable; req_ready=1, settled=1.
  - BREAK: both paths off; req_ready=0, settled=0.
  - MAKE: target path on; req_ready=0, settled=0.
- Accept = req_valid && req_ready at an edge (E0). req_sel=11 is accepted as 00 and sets err_sticky at E0.
- Target equal to current stable state: no change; settled and req_ready stay 1.
- From ON1_ST/ON2_ST to a different target:
  - At E0, enter BREAK; both paths off; counter loads DEAD_CYC-1.
  - Exit after exactly DEAD_CYC cycles in BREAK, at edge E0+DEAD_CYC.
    - Target off: enter OFF_ST; settled and req_ready high from E0+DEAD_CYC.
    - Target path: enter MAKE; path on from E0+DEAD_CYC; cur_sel updates at the same edge.
- From OFF_ST to a path: BREAK is skipped. Enter MAKE at E0; target on and cur_sel updated at E0.
- MAKE: counter loads SETTLE_CYC-1; exit after SETTLE_CYC cycles to ON1_ST/ON2_ST; settled=req_ready=1 from E(make entry)+SETTLE_CYC.
- Latencies:
  - Path-to-path: E0+DEAD_CYC+SETTLE_CYC.
  - Off-to-path: E0+SETTLE_CYC.
  - Path-to-off: E0+DEAD_CYC.
- req_valid while req_ready=0 is ignored. The requester must hold it; there is no queueing.
- Counter decrements by 1 per cycle and never wraps; exit condition is counter==0.
- err_clr: clears err_sticky at the next edge. If an illegal request is accepted at the same edge, the set wins.

Test Plan:
1. Reset, then req_sel=01 with valid for one cycle at edge E0 -> ckn1=1/ckp1=0 from E0, cur_sel=01; settled=req_ready=1 at E0+3 (defaults); path 2 stays off throughout.
2. From ON1_ST, request 10 -> path 1 off at E0; both off for exactly 2 cycles; path 2 on at E0+2; settled at E0+5; never both ckn high.
3. From ON2_ST, request 00 -> both off at E0; settled at E0+2; cur_sel=00. Then request 00 again -> no state change, ready stays 1.
4. Request 11 from ON1_ST -> behaves as off (settled at E0+2), err_sticky=1. err_clr pulse -> 0 next edge. err_clr coincident with a new 11 accept -> err_sticky stays 1.
5. Assert rst_n=0 in BREAK and again in MAKE -> next edge all paths off, cur_sel=00, settled=req_ready=1; toggling req_valid while req_ready=0 never alters timing.
6. DEAD_CYC=1, SETTLE_CYC=1, back-to-back 01->10->01 requests held valid -> each switch completes in 2 cycles, exact-edge checks on every select line.
